dtfm_transmitter: RTL and testbench
===================================

Name: dtfm_transmitter

Overview:
Serialiser for the DTFM telemetry link, driving the same three-wire interface that the receive side decodes: bit clock, serial data and frame sync.
- Accepts 16-bit words over a valid/ready handshake into a one-word holding register.
- Shifts each word out MSB-first on a generated bit clock.
- Asserts sync for the whole of word 0 of every frame.
- Used for loopback test rigs and for feeding downstream DTFM decoders from the telemetry formatter.

Parameters:
HALF_DIV, 2, clk cycles per half bit-clock period (bit period = 2*HALF_DIV clk); legal range >=1
WORD_W, 16, word width in bits
FRAME_WORDS, 32, words per frame; sync marks word 0
IDLE_WORD, 16'h0000, word transmitted on underflow

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; sampled at frame boundaries
word  in  WORD_W  parallel word to send
valid  in  1  word is valid
ready  out  1  holding register can accept (= holding empty)
dClk  out  1  serial bit clock; idle low
dData  out  1  serial data, MSB first
dSync  out  1  frame sync; high during word 0 of each frame
busy  out  1  high while in SHIFT
underflow  out  1  one-cycle pulse when IDLE_WORD is substituted
wordCnt  out  $clog2(FRAME_WORDS)  index of word currently on the line

Behaviour:
- Reset (reset=0, asynchronous) forces the following values immediately, including mid-word:
  - state IDLE, holding register empty, ready=1
  - dClk=0, dData=0, dSync=0, busy=0, underflow=0, wordCnt=0
  - bit and divider counters cleared
  - on release, no partial word is resumed.
- Handshake: transfer occurs when valid && ready. The word is held until loaded into the shifter; ready=0 while the holding register is full.
- Bypass: if a transfer and a shifter load happen in the same cycle with the holding register empty, the incoming word goes straight to the shifter and the holding register stays empty.
- State IDLE:
  - outputs at idle values
  - transition to SHIFT when enable=1 and holding full; the shifter loads in the transition cycle.
  - Latency: transfer at cycle T, SHIFT entered at T+2 with dData=MSB, dSync=1, wordCnt=0.
- State SHIFT, bit timing:
  - each bit lasts 2*HALF_DIV clk cycles
  - dClk=0 for the first HALF_DIV cycles and 1 for the remaining HALF_DIV cycles; the receiver samples on the dClk rising edge
  - dData and dSync change only at bit boundaries, coincident with the dClk falling edge.
- State SHIFT, word boundary (end of bit 0):
  - wordCnt increments, wrapping FRAME_WORDS-1 -> 0
  - next word loads from the holding register, or via bypass
  - if no word is available, IDLE_WORD loads and underflow pulses for 1 cycle. The frame stays intact; wordCnt still advances and the line timing is unbroken.
- State SHIFT, frame boundary (end of word FRAME_WORDS-1):
  - if enable=0, go to IDLE
  - the held word is kept and the holding register is not flushed.
  - enable deasserted mid-frame has no effect until the frame boundary.
- dSync=1 for all WORD_W bits of word 0, 0 otherwise.
- busy=1 exactly while the state is SHIFT.
- Back-to-back words: no gap bits; the next word's MSB immediately follows the previous LSB.

Decomposition:
- Package dtfm_pkg:
  - state enum {IDLE, SHIFT}
  - DTFM_WORD_W=16 and default frame-length constants, shared with the receiver and filler.
- Sub-module dtfm_bit_timer:
  - HALF_DIV divider producing the dClk level, plus one-cycle bitStart and bitEnd strobes
  - cleared while the state is IDLE.

Test Plan:
- Word path: HALF_DIV=2, enable=1, send 16'hA5C3 -> dData reads 1010010111000011 on 16 dClk rising edges; dClk period 4 clk; dSync high for exactly 64 clk; first bit at T+2 after transfer.
- Frame: FRAME_WORDS=4, stream 16'h0001..16'h0008 continuously -> no gaps; dSync high during words 0001 and 0005 only; wordCnt sequence 0,1,2,3,0,1,2,3; ready toggles once per word.
- Underflow: stop supplying words after word 1 of a frame -> words 2 and 3 are 16'h0000, with an underflow pulse of 1 cycle at each of those word boundaries; frame length preserved.
- Enable drop: deassert enable during word 1 with FRAME_WORDS=4 -> words 2 and 3 are still sent, then IDLE; busy falls after the LSB of word 3; a held word remains and ready=0.
- Reset mid-word: assert reset during bit 7 of 16'hFFFF -> dClk, dData and dSync are 0 immediately; after release with enable=1, a new word starts cleanly at MSB with dSync=1.
- Bypass: hold valid=1 continuously, with the holding register empty at the word boundary -> no IDLE_WORD inserted; underflow stays 0.

Source files
------------

// File: rtl/dtfm_pkg.sv
// Shared DTFM link definitions used by the transmitter, receiver and filler.
package dtfm_pkg;

  localparam int unsigned DTFM_WORD_W      = 16;
  localparam int unsigned DTFM_FRAME_WORDS = 32;
  localparam int unsigned DTFM_HALF_DIV    = 2;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/dtfm_bit_timer.sv
// Bit-clock generator: dClk low for HALF_DIV cycles then high for HALF_DIV,
// with strobes on the first and last clk cycle of every bit. Held cleared
// while run is low.
module dtfm_bit_timer
  import dtfm_pkg::*;
#(
  parameter int unsigned HALF_DIV = DTFM_HALF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic dClk,
  output logic bitStart,
  output logic bitEnd
);

  localparam int unsigned   CW   = $clog2(2 * HALF_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * HALF_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(HALF_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dclk_q, dclk_d;

  // Phase counter and next dClk level; dClk is registered from the next
  // phase so it always equals (phase >= HALF_DIV) without a decode glitch.
  always_comb begin
    bitStart = run && (cnt_q == '0);
    bitEnd   = run && (cnt_q == LAST);
    cnt_d    = '0;
    if (run && !bitEnd) begin
      cnt_d = cnt_q + 1'b1;
    end
    dclk_d = (cnt_d >= HALF);
  end

  // Divider state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      dclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
    end
  end

  assign dClk = dclk_q;

endmodule

// File: rtl/dtfm_transmitter.sv
// DTFM serialiser: one-word holding register behind a valid/ready handshake,
// MSB-first shifter on a generated bit clock, sync during word 0 of a frame.
module dtfm_transmitter
  import dtfm_pkg::*;
#(
  parameter int unsigned            HALF_DIV    = DTFM_HALF_DIV,
  parameter int unsigned            WORD_W      = DTFM_WORD_W,
  parameter int unsigned            FRAME_WORDS = DTFM_FRAME_WORDS,
  parameter logic [WORD_W-1:0]      IDLE_WORD   = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WORD_W-1:0]              word,
  input  logic                           valid,
  output logic                           ready,
  output logic                           dClk,
  output logic                           dData,
  output logic                           dSync,
  output logic                           busy,
  output logic                           underflow,
  output logic [$clog2(FRAME_WORDS)-1:0] wordCnt
);

  localparam int unsigned WCW = $clog2(FRAME_WORDS);
  localparam int unsigned BW  = $clog2(WORD_W);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic              sync_q, sync_d;
  logic              sub_q, sub_d;

  logic              bit_start, bit_end;
  logic              xfer, take;
  logic              frame_last;
  logic [WCW-1:0]    wnext;

  dtfm_bit_timer #(
    .HALF_DIV(HALF_DIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == SHIFT),
    .dClk     (dClk),
    .bitStart (bit_start),
    .bitEnd   (bit_end)
  );

  // Next-state logic. An incoming word normally lands in the holding
  // register; at a word boundary with the holding register empty it is
  // steered straight into the shifter instead (take cleared).
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    wcnt_d      = wcnt_q;
    sync_d      = sync_q;
    sub_d       = sub_q;
    xfer        = valid && !hold_full_q;
    take        = xfer;
    frame_last  = (wcnt_q == WCW'(FRAME_WORDS - 1));
    wnext       = frame_last ? '0 : wcnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (enable && hold_full_q) begin
          state_d     = SHIFT;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          wcnt_d      = '0;
          bit_d       = BW'(WORD_W - 1);
          sync_d      = 1'b1;
          sub_d       = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bit_q != '0) begin
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
          end else if (frame_last && !enable) begin
            state_d = IDLE;
            shift_d = '0;
            wcnt_d  = '0;
            sync_d  = 1'b0;
            sub_d   = 1'b0;
          end else begin
            wcnt_d = wnext;
            sync_d = (wnext == '0);
            bit_d  = BW'(WORD_W - 1);
            sub_d  = 1'b0;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (xfer) begin
              shift_d = word;
              take    = 1'b0;
            end else begin
              shift_d = IDLE_WORD;
              sub_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      hold_d      = word;
      hold_full_d = 1'b1;
    end
  end

  // Transmitter state, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      wcnt_q      <= '0;
      sync_q      <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      wcnt_q      <= wcnt_d;
      sync_q      <= sync_d;
      sub_q       <= sub_d;
    end
  end

  assign ready     = !hold_full_q;
  assign busy      = (state_q == SHIFT);
  assign dData     = shift_q[WORD_W-1];
  assign dSync     = sync_q;
  assign wordCnt   = wcnt_q;
  // Substituted word flagged for its first clk cycle only.
  assign underflow = bit_start && sub_q && (bit_q == BW'(WORD_W - 1));

endmodule

// File: tb/tb_dtfm_transmitter.sv
// Self-checking bench for dtfm_transmitter (HALF_DIV=2, FRAME_WORDS=4).
module tb_dtfm_transmitter;

  localparam int H     = 2;
  localparam int W     = 16;
  localparam int FW    = 4;
  localparam int BITC  = 2 * H;
  localparam int WORDC = BITC * W;
  localparam logic [15:0] IDLE_W = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] word = '0;
  logic        ready, dClk, dData, dSync, busy, underflow;
  logic [1:0]  wordCnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dtfm_transmitter #(
    .HALF_DIV(H),
    .WORD_W(W),
    .FRAME_WORDS(FW),
    .IDLE_WORD(IDLE_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .word(word), .valid(valid),
    .ready(ready), .dClk(dClk), .dData(dData), .dSync(dSync), .busy(busy),
    .underflow(underflow), .wordCnt(wordCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Line-level model: the line is described by the cycle count since the
  // line started (m_k) and the sequence of words placed on it.
  bit          m_run = 0, m_full = 0, m_up = 0;
  int          m_k = 0, m_widx = 0;
  logic [15:0] m_cur = '0, m_hold = '0;

  task automatic model_step(input bit en, input bit v, input logic [15:0] w);
    bit xfer, keep;
    xfer = v && !m_full;
    keep = xfer;
    m_up = 0;
    if (!m_run) begin
      if (en && m_full) begin
        m_run = 1; m_k = 0; m_widx = 0; m_cur = m_hold; m_full = 0;
      end
    end else if ((m_k + 1) % WORDC != 0) begin
      m_k++;
    end else if ((m_widx % FW) == FW - 1 && !en) begin
      m_run = 0; m_k = 0; m_widx = 0;
    end else begin
      m_k++; m_widx++;
      if (m_full) begin m_cur = m_hold; m_full = 0; end
      else if (xfer) begin m_cur = w; keep = 0; end
      else begin m_cur = IDLE_W; m_up = 1; end
    end
    if (keep) begin m_hold = w; m_full = 1; end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_full = 0; m_up = 0; m_k = 0; m_widx = 0; m_cur = '0; m_hold = '0;
    end else begin
      model_step(enable, valid, word);
    end
  end

  int sync_cyc = 0, up_cyc = 0;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic [7:0] e, g;
    int bi;
    bi = W - 1 - ((m_k / BITC) % W);
    e = {!m_full,
         m_run && ((m_k % BITC) >= H),
         m_run && m_cur[bi],
         m_run && ((m_widx % FW) == 0),
         m_run,
         m_up,
         m_run ? 2'(m_widx % FW) : 2'd0};
    g = {ready, dClk, dData, dSync, busy, underflow, wordCnt};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL cycle %0d {ready,dClk,dData,dSync,busy,underflow,wordCnt}: got %b expected %b", cyc, g, e);
    end
    if (dSync) sync_cyc++;
    if (underflow) up_cyc++;
  end

  // Independent receiver: samples dData on dClk rising edges.
  logic [15:0] rx_sr = '0;
  int          rx_n = 0;
  logic [15:0] rx_q[$];
  int          rx_s[$];
  int          rx_wc[$];
  int          rise_cyc[$];

  always @(posedge dClk or negedge reset) begin
    if (!reset) begin
      rx_n = 0; rx_sr = '0;
    end else begin
      rx_sr = {rx_sr[14:0], dData};
      rx_n++;
      rise_cyc.push_back(cyc);
      if (rx_n == W) begin
        rx_q.push_back(rx_sr);
        rx_s.push_back(int'(dSync));
        rx_wc.push_back(int'(wordCnt));
        rx_n = 0;
      end
    end
  end

  task automatic clear_stats();
    rx_q.delete(); rx_s.delete(); rx_wc.delete(); rise_cyc.delete();
    sync_cyc = 0; up_cyc = 0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    valid = 1'b1; word = w;
    while (!ready && n < 2000) begin @(negedge clk); n++; end
    chk("send_accepted_in_budget", int'(n < 2000), 1);
    @(negedge clk);
  endtask

  task automatic wait_busy(output int c);
    int n;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    c = cyc;
    chk("busy_in_budget", int'(n < 50), 1);
  endtask

  int fall_cyc = 0;
  task automatic wait_done();
    int n;
    bit seen;
    n = 0; seen = busy;
    while (!(seen && !busy) && n < 3000) begin
      @(negedge clk); n++;
      if (busy) seen = 1;
    end
    fall_cyc = cyc;
    chk("done_in_budget", int'(n < 3000), 1);
  endtask

  task automatic chk_rx(input string tag, input logic [15:0] e0, e1, e2, e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_nwords"}, rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_word%0d", tag, i), (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(e[i]));
    chk({tag, "_sync_word0"}, (rx_s.size() > 0) ? rx_s[0] : -1, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t_x, t_b, n;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_line_idle", int'({dClk, dData, dSync, busy, underflow, wordCnt}), 0);
    reset = 1'b1;
    @(negedge clk);

    // Word path: A5C3 then three substituted idle words.
    clear_stats();
    enable = 1'b1;
    t_x = cyc; valid = 1'b1; word = 16'hA5C3;
    @(negedge clk); valid = 1'b0;
    wait_busy(t_b);
    chk("wp_latency", t_b - t_x, 2);
    chk("wp_first_msb", dData, 1);
    chk("wp_first_sync", dSync, 1);
    chk("wp_first_wordcnt", wordCnt, 0);
    enable = 1'b0;
    wait_done();
    chk_rx("wp", 16'hA5C3, 16'h0000, 16'h0000, 16'h0000);
    chk("wp_sync_cycles", sync_cyc, 64);
    chk("wp_underflow_cycles", up_cyc, 3);
    chk("wp_dclk_rises", rise_cyc.size(), 64);
    chk("wp_dclk_period", (rise_cyc.size() >= 2) ? rise_cyc[1] - rise_cyc[0] : -1, 4);

    // Two back-to-back frames of 0001..0008.
    clear_stats();
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i));
    enable = 1'b0; valid = 1'b0;
    wait_done();
    chk("fr_nwords", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fr_word%0d", i), (i < rx_q.size()) ? int'(rx_q[i]) : -1, i + 1);
      chk($sformatf("fr_sync%0d", i), (i < rx_s.size()) ? rx_s[i] : -1, int'((i % 4) == 0));
      chk($sformatf("fr_wordcnt%0d", i), (i < rx_wc.size()) ? rx_wc[i] : -1, i % 4);
    end
    chk("fr_underflow_cycles", up_cyc, 0);
    chk("fr_sync_cycles", sync_cyc, 128);

    // Underflow after word 1.
    clear_stats();
    enable = 1'b1;
    send(16'h1111); send(16'h2222);
    valid = 1'b0; enable = 1'b0;
    wait_done();
    chk_rx("uf", 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    chk("uf_underflow_cycles", up_cyc, 2);
    chk("uf_frame_bits", rise_cyc.size(), 64);

    // Enable dropped during word 1; last word stays held.
    clear_stats();
    enable = 1'b1;
    send(16'h3001); send(16'h3002); send(16'h3003);
    enable = 1'b0;
    send(16'h3004); send(16'h3005);
    valid = 1'b0;
    wait_done();
    chk_rx("ed", 16'h3001, 16'h3002, 16'h3003, 16'h3004);
    chk("ed_busy_fall_after_lsb", (rise_cyc.size() > 0) ? fall_cyc - rise_cyc[$] : -1, H);
    repeat (3) @(negedge clk);
    chk("ed_ready_held", ready, 0);
    chk("ed_busy_idle", busy, 0);

    // Reset flushes the held word.
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_flush_ready", ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Reset during bit 7 of FFFF.
    clear_stats();
    enable = 1'b1;
    send(16'hFFFF);
    valid = 1'b0;
    n = 0;
    while (!(rx_n == 9 && dClk) && n < 300) begin @(negedge clk); n++; end
    chk("mr_reached_bit7", int'(n < 300), 1);
    chk("mr_pre_dclk", dClk, 1);
    chk("mr_pre_ddata", dData, 1);
    chk("mr_pre_dsync", dSync, 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_dclk", dClk, 0);
    chk("mr_ddata", dData, 0);
    chk("mr_dsync", dSync, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", ready, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    clear_stats();
    send(16'h8001);
    valid = 1'b0;
    wait_busy(t_b);
    chk("mr_new_msb", dData, 1);
    chk("mr_new_sync", dSync, 1);
    enable = 1'b0;
    wait_done();
    chk_rx("mr", 16'h8001, 16'h0000, 16'h0000, 16'h0000);

    // Bypass: word offered exactly at the boundary with holding empty.
    clear_stats();
    enable = 1'b1;
    send(16'h4001);
    valid = 1'b0;
    wait_busy(t_b);
    n = 0;
    while (!(m_run && (m_k % WORDC) == WORDC - 1) && n < 200) begin @(negedge clk); n++; end
    chk("bp_boundary_found", int'(n < 200), 1);
    chk("bp_ready_at_boundary", ready, 1);
    valid = 1'b1; word = 16'h4002;
    @(negedge clk);
    chk("bp_holding_still_empty", ready, 1);
    send(16'h4003); send(16'h4004);
    valid = 1'b0; enable = 1'b0;
    wait_done();
    chk_rx("bp", 16'h4001, 16'h4002, 16'h4003, 16'h4004);
    chk("bp_underflow_cycles", up_cyc, 0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
